// File: rtl/spi_flash_read_seq.sv
// SPI flash READ sequencer: CS setup, opcode, address, data stream, CS deselect.
// Define SPI_FLASH_FAST_READ_EN for fast read (0Bh + one dummy byte).
module spi_flash_read_seq #(
  parameter int         ADDR_W   = 24,
  parameter int         LEN_W    = 16,
  parameter int         CS_SETUP = 2,
  parameter int         CS_DESEL = 4,
  parameter logic [7:0] READ_CMD = 8'h03
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              done,
  output logic              busy,
  output logic              cs_n,
  output logic              spi_req,
  input  logic              spi_ack,
  output logic [7:0]        spi_d,
  input  logic [7:0]        spi_q,
  output logic              spi_fast
);

  localparam int NB = ADDR_W / 8;
  localparam logic [15:0] SETUP_INIT = 16'(CS_SETUP - 1);
  localparam logic [15:0] DESEL_INIT = 16'(CS_DESEL - 1);
  localparam logic [15:0] ADDR_INIT  = 16'(NB - 1);

`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic [7:0] OPCODE = 8'h0B;
  localparam logic       FAST   = 1'b1;
`else
  localparam logic [7:0] OPCODE = READ_CMD;
  localparam logic       FAST   = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, SETUP, CMD, ADDR, DUMMY, DATA, DRAIN, DESEL
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  logic [15:0]       cnt_q;
  logic              wait_q;
  logic              cmd_ready_q;
  logic [7:0]        rd_data_q;
  logic              rd_valid_q;
  logic              done_q;
  logic              busy_q;
  logic              cs_n_q;
  logic              req_q;
  logic [7:0]        spi_d_q;
  logic              fast_q;

  logic cmpl;
  logic rd_free;

  // Outstanding byte finished: engine ack has caught up with our request.
  assign cmpl    = wait_q && (spi_ack == req_q);
  // Output slot is empty, or is being emptied this cycle.
  assign rd_free = !rd_valid_q || rd_ready;

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      wait_q      <= 1'b0;
      cmd_ready_q <= 1'b0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      cs_n_q      <= 1'b1;
      req_q       <= 1'b0;
      spi_d_q     <= '0;
      fast_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (rd_valid_q && rd_ready) rd_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            addr_q <= cmd_addr;
            rem_q  <= cmd_len;
            if (cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              cmd_ready_q <= 1'b0;
              busy_q      <= 1'b1;
              cs_n_q      <= 1'b0;
              cnt_q       <= SETUP_INIT;
              state_q     <= SETUP;
            end
          end
        end
        SETUP: begin
          if (cnt_q == '0) begin
            fast_q  <= FAST;
            state_q <= CMD;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        CMD: begin
          if (!wait_q) begin
            spi_d_q <= OPCODE;
            req_q   <= ~req_q;
            wait_q  <= 1'b1;
          end else if (cmpl) begin
            wait_q  <= 1'b0;
            cnt_q   <= ADDR_INIT;
            state_q <= ADDR;
          end
        end
        ADDR: begin
          if (!wait_q) begin
            spi_d_q <= addr_q[ADDR_W-1 -: 8];
            req_q   <= ~req_q;
            wait_q  <= 1'b1;
          end else if (cmpl) begin
            wait_q <= 1'b0;
            addr_q <= addr_q << 8;
            if (cnt_q == '0) state_q <= FAST ? DUMMY : DATA;
            else             cnt_q   <= cnt_q - 16'd1;
          end
        end
        DUMMY: begin
          if (!wait_q) begin
            spi_d_q <= 8'h00;
            req_q   <= ~req_q;
            wait_q  <= 1'b1;
          end else if (cmpl) begin
            wait_q  <= 1'b0;
            state_q <= DATA;
          end
        end
        DATA: begin
          if (!wait_q) begin
            if (rd_free && rem_q != '0) begin
              spi_d_q <= 8'h00;
              req_q   <= ~req_q;
              wait_q  <= 1'b1;
            end
          end else if (cmpl) begin
            wait_q     <= 1'b0;
            rd_data_q  <= spi_q;
            rd_valid_q <= 1'b1;
            rem_q      <= rem_q - LEN_W'(1);
            if (rem_q == LEN_W'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (!rd_valid_q) begin
            cs_n_q  <= 1'b1;
            fast_q  <= 1'b0;
            cnt_q   <= DESEL_INIT;
            state_q <= DESEL;
          end
        end
        DESEL: begin
          if (cnt_q == '0) begin
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign busy      = busy_q;
  assign cs_n      = cs_n_q;
  assign spi_req   = req_q;
  assign spi_d     = spi_d_q;
  assign spi_fast  = fast_q;

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Bench for spi_flash_read_seq: byte-engine stub, transaction model, monitor.
// Builds with or without SPI_FLASH_FAST_READ_EN.
`timescale 1ns/1ps
module tb_spi_flash_read_seq;

  localparam int CS_SETUP = 2;
  localparam int CS_DESEL = 4;
  localparam int LAT      = 3;
`ifdef SPI_FLASH_FAST_READ_EN
  localparam logic       FASTB = 1'b1;
  localparam logic [7:0] OPC   = 8'h0B;
  localparam int         HDR   = 5;
`else
  localparam logic       FASTB = 1'b0;
  localparam logic [7:0] OPC   = 8'h03;
  localparam int         HDR   = 4;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [23:0] cmd_addr = '0;
  logic [15:0] cmd_len = '0;
  logic [7:0]  rd_data;
  logic        rd_valid;
  logic        rd_ready = 1'b0;
  logic        done;
  logic        busy;
  logic        cs_n;
  logic        spi_req;
  logic        spi_ack;
  logic [7:0]  spi_d;
  logic [7:0]  spi_q;
  logic        spi_fast;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;

  logic [7:0] resp [16];
  logic [7:0] exp_mosi [$];
  logic [7:0] exp_rd [$];
  logic [7:0] mosi_log [$];
  logic [7:0] got_log [$];

  spi_flash_read_seq dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .busy(busy), .cs_n(cs_n),
    .spi_req(spi_req), .spi_ack(spi_ack),
    .spi_d(spi_d), .spi_q(spi_q), .spi_fast(spi_fast)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Byte engine stub: fixed latency, returns resp[] after the header bytes.
  int idx;
  int lat;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      spi_ack <= 1'b0;
      spi_q   <= 8'h00;
      idx     <= 0;
      lat     <= 0;
    end else begin
      if (cs_n) idx <= 0;
      if (spi_req != spi_ack) begin
        if (lat == LAT - 1) begin
          spi_ack <= spi_req;
          spi_q   <= (idx >= HDR) ? resp[(idx - HDR) & 15] : 8'hEE;
          idx     <= idx + 1;
          lat     <= 0;
        end else begin
          lat <= lat + 1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: what the wire and the stream must carry.
  task automatic expect_read(input logic [23:0] a, input logic [15:0] l);
    if (l == 0) return;
    exp_mosi.push_back(OPC);
    exp_mosi.push_back(a[23:16]);
    exp_mosi.push_back(a[15:8]);
    exp_mosi.push_back(a[7:0]);
    if (FASTB) exp_mosi.push_back(8'h00);
    for (int i = 0; i < int'(l); i++) begin
      exp_mosi.push_back(8'h00);
      exp_rd.push_back(resp[i & 15]);
    end
  endtask

  // Monitor: compares DUT against the model every cycle.
  initial begin
    logic       prev_req;
    logic       prev_cs;
    logic       prev_done;
    logic       first_pend;
    logic       have_prev;
    logic [7:0] last_d;
    int         cs_low;
    int         cs_hi;
    prev_req = 0; prev_cs = 1; prev_done = 0;
    first_pend = 0; have_prev = 0; last_d = 0;
    cs_low = 0; cs_hi = 0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_req = 0; prev_cs = 1; prev_done = 0;
        first_pend = 0; have_prev = 0; cs_low = 0; cs_hi = 0;
        continue;
      end
      if (!cs_n) begin
        if (prev_cs) begin
          first_pend = 1;
          cs_low = 0;
          if (have_prev) chk("cs_desel_gap", 32'(cs_hi >= CS_DESEL), 1);
        end
        cs_low++;
      end else begin
        if (!prev_cs) begin
          cs_hi = 0;
          have_prev = 1;
          chk("cs_rise_pending", 32'(spi_req ^ spi_ack), 0);
        end
        cs_hi++;
        chk("fast_idle", 32'(spi_fast), 0);
      end
      if (spi_req != prev_req) begin
        chk("req_cs_low", 32'(cs_n), 0);
        if (first_pend) begin
          chk("cs_setup", 32'(cs_low > CS_SETUP), 1);
          first_pend = 0;
        end
        if (exp_mosi.size() == 0) chk("mosi_unexpected", 1, 0);
        else chk("mosi_byte", 32'(spi_d), 32'(exp_mosi.pop_front()));
        mosi_log.push_back(spi_d);
        last_d = spi_d;
      end else if (spi_req != spi_ack) begin
        chk("spi_d_stable", 32'(spi_d), 32'(last_d));
      end
      if (spi_req != spi_ack) chk("spi_fast", 32'(spi_fast), 32'(FASTB));
      prev_req = spi_req;
      if (rd_valid && rd_ready) begin
        if (exp_rd.size() == 0) chk("rd_unexpected", 1, 0);
        else chk("rd_byte", 32'(rd_data), 32'(exp_rd.pop_front()));
        got_log.push_back(rd_data);
      end
      if (cmd_ready && busy) chk("ready_while_busy", 1, 0);
      if (done) begin
        done_cnt++;
        if (prev_done) chk("done_one_cycle", 1, 0);
      end
      prev_done = done;
      prev_cs = cs_n;
    end
  end

  task automatic start(input logic [23:0] a, input logic [15:0] l);
    int n;
    expect_read(a, l);
    @(negedge clk);
    cmd_addr = a;
    cmd_len = l;
    cmd_valid = 1'b1;
    #1;
    n = 0;
    while (!cmd_ready && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 0, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < 3000) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt < target) chk("done_timeout", 32'(done_cnt), 32'(target));
    repeat (3) @(negedge clk);
  endtask

  task automatic check_empty();
    chk("mosi_left", 32'(exp_mosi.size()), 0);
    chk("rd_left", 32'(exp_rd.size()), 0);
  endtask

  initial begin
    int base;
    int gbase;
    int dbase;
    int n;
    logic r;
    logic [7:0] lit [8];
    for (int i = 0; i < 16; i++) resp[i] = 8'(8'h10 + i);

    // Reset values
    repeat (3) @(negedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 0);
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_cs_n", 32'(cs_n), 1);
    chk("rst_spi_req", 32'(spi_req), 0);
    chk("rst_spi_d", 32'(spi_d), 0);
    chk("rst_spi_fast", 32'(spi_fast), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle_cmd_ready", 32'(cmd_ready), 1);

    // Basic read of 3 bytes
    resp[0] = 8'hAA; resp[1] = 8'hBB; resp[2] = 8'hCC;
    rd_ready = 1'b1;
    base = mosi_log.size();
    gbase = got_log.size();
    dbase = done_cnt;
    start(24'h012345, 16'd3);
    wait_done(dbase + 1);
    chk("t1_done_count", 32'(done_cnt), 32'(dbase + 1));
    check_empty();
`ifndef SPI_FLASH_FAST_READ_EN
    lit = '{8'h03, 8'h01, 8'h23, 8'h45, 8'h00, 8'h00, 8'h00, 8'h00};
    chk("t1_mosi_len", 32'(mosi_log.size() - base), 7);
    for (int i = 0; i < 7; i++)
      if (base + i < mosi_log.size())
        chk("t1_mosi_lit", 32'(mosi_log[base + i]), 32'(lit[i]));
`endif
    chk("t1_rd_len", 32'(got_log.size() - gbase), 3);
    if (got_log.size() >= gbase + 3) begin
      chk("t1_rd0", 32'(got_log[gbase]), 32'hAA);
      chk("t1_rd1", 32'(got_log[gbase + 1]), 32'hBB);
      chk("t1_rd2", 32'(got_log[gbase + 2]), 32'hCC);
    end

    // Zero length: done next cycle, no SPI activity
    dbase = done_cnt;
    r = spi_req;
    @(negedge clk);
    cmd_addr = 24'h000777;
    cmd_len = 16'd0;
    cmd_valid = 1'b1;
    #1;
    chk("z_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    #1;
    chk("z_done", 32'(done), 1);
    chk("z_cs_n", 32'(cs_n), 1);
    @(negedge clk);
    #1;
    chk("z_done_low", 32'(done), 0);
    chk("z_spi_req", 32'(spi_req), 32'(r));
    chk("z_cs_n2", 32'(cs_n), 1);
    chk("z_busy", 32'(busy), 0);

    // Backpressure: hold first byte for 20 cycles
    resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
    rd_ready = 1'b0;
    gbase = got_log.size();
    dbase = done_cnt;
    start(24'h000100, 16'd4);
    n = 0;
    while (!rd_valid && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("bp_first_valid", 32'(rd_valid), 1);
    r = spi_req;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("bp_req_hold", 32'(spi_req), 32'(r));
      chk("bp_data_hold", 32'(rd_data), 32'h11);
      chk("bp_valid_hold", 32'(rd_valid), 1);
    end
    @(negedge clk);
    rd_ready = 1'b1;
    wait_done(dbase + 1);
    check_empty();
    lit = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00};
    chk("bp_rd_len", 32'(got_log.size() - gbase), 4);
    for (int i = 0; i < 4; i++)
      if (gbase + i < got_log.size())
        chk("bp_rd_lit", 32'(got_log[gbase + i]), 32'(lit[i]));

    // Back-to-back requests
    dbase = done_cnt;
    start(24'hABCDEF, 16'd2);
    start(24'h000010, 16'd1);
    wait_done(dbase + 2);
    chk("b2b_done_count", 32'(done_cnt), 32'(dbase + 2));
    check_empty();

    // Reset during address phase
    dbase = done_cnt;
    base = mosi_log.size();
    start(24'h00ABCD, 16'd2);
    n = 0;
    while (mosi_log.size() < base + 2 && n < 400) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("rst_mid_reached_addr", 32'(mosi_log.size() >= base + 2), 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_cs_n", 32'(cs_n), 1);
    chk("rst_mid_busy", 32'(busy), 0);
    chk("rst_mid_req", 32'(spi_req), 0);
    exp_mosi.delete();
    exp_rd.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_rel_ready", 32'(cmd_ready), 1);
    chk("rst_rel_busy", 32'(busy), 0);
    chk("rst_rel_req", 32'(spi_req), 0);
    repeat (10) @(negedge clk);
    chk("rst_no_done", 32'(done_cnt), 32'(dbase));

`ifdef SPI_FLASH_FAST_READ_EN
    // Fast read of one byte from address 0
    resp[0] = 8'h5A;
    base = mosi_log.size();
    gbase = got_log.size();
    dbase = done_cnt;
    start(24'h000000, 16'd1);
    wait_done(dbase + 1);
    check_empty();
    lit = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    chk("fast_mosi_len", 32'(mosi_log.size() - base), 6);
    for (int i = 0; i < 6; i++)
      if (base + i < mosi_log.size())
        chk("fast_mosi_lit", 32'(mosi_log[base + i]), 32'(lit[i]));
    chk("fast_rd_len", 32'(got_log.size() - gbase), 1);
    if (got_log.size() > gbase)
      chk("fast_rd0", 32'(got_log[gbase]), 32'h5A);
`endif

    // Recovery read after reset
    resp[0] = 8'h9C; resp[1] = 8'h3E;
    dbase = done_cnt;
    start(24'hFFFFFE, 16'd2);
    wait_done(dbase + 1);
    check_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_flash_read_seq.md
Name: spi_flash_read_seq

Overview:
- Command sequencer directly upstream of the SPI master byte engine.
- Turns one host read request (address, length) into a complete SPI flash READ transaction: chip-select, opcode, 24-bit address, optional dummy byte, then N data bytes.
- Drives the master's toggle req/ack byte handshake and delivers received bytes on a valid/ready stream.
- Used for flash boot and ROM fetch paths.

Parameters:
- ADDR_W, 24, flash address width; must be a multiple of 8, sent MSB byte first.
- LEN_W, 16, width of the byte-count field.
- CS_SETUP, 2, clk cycles from cs_n falling to the first byte request (min 1).
- CS_DESEL, 4, min clk cycles cs_n stays high after a transaction (min 1).
- READ_CMD, 8'h03, opcode for the normal read.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- cmd_valid  in  1  host request valid.
- cmd_ready  out  1  high in IDLE only; request accepted on cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_W  start byte address.
- cmd_len  in  LEN_W  number of data bytes; 0 means no transaction.
- rd_data  out  8  received byte.
- rd_valid  out  1  rd_data valid; held until rd_ready.
- rd_ready  in  1  consumer accepts byte.
- done  out  1  one-cycle pulse when the request is fully finished.
- busy  out  1  high whenever the block is not in IDLE.
- cs_n  out  1  flash chip select, active low.
- spi_req  out  1  toggle request to the byte engine.
- spi_ack  in  1  toggle acknowledge from the byte engine.
- spi_d  out  8  byte to transmit; stable while spi_req != spi_ack.
- spi_q  in  8  received byte; valid when spi_ack == spi_req.
- spi_fast  out  1  fast_speed_en to the byte engine.

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE. rd_valid=0, rd_data=0, done=0, busy=0, cs_n=1, spi_req=0, spi_d=0, spi_fast=0.
- Reset is asserted together with the byte engine's reset, so req and ack restart equal at 0.
- Handshake: a byte is issued by loading spi_d and inverting spi_req in the same cycle. It is complete when spi_ack == spi_req; spi_q is captured in that cycle. Only one byte is outstanding at a time.
- FSM states: IDLE, SETUP, CMD, ADDR, DUMMY, DATA, DRAIN, DESEL.
- IDLE:
  - Accept when cmd_valid. Latch addr and len.
  - If len==0: pulse done the next cycle and stay in IDLE; cs_n is untouched.
  - Otherwise: cs_n<=0, go to SETUP with counter=CS_SETUP-1.
- SETUP: count down to 0, then go to CMD.
- CMD: issue READ_CMD. On completion, go to ADDR; the received byte is discarded.
- ADDR: issue ADDR_W/8 bytes, MSB byte first, using a byte counter. After the last completion go to DATA, or to DUMMY when the fast feature is enabled.
- DATA:
  - Issue 8'h00 only when rd_valid==0 and remaining>0.
  - On completion: rd_data<=spi_q, rd_valid<=1, remaining<=remaining-1.
  - When remaining reaches 0, go to DRAIN.
- Output register: rd_valid clears on rd_ready. Back-to-back issue is allowed in the cycle rd_valid falls. Max one byte buffered, so SPI simply stalls under backpressure.
- DRAIN: wait until rd_valid==0, then cs_n<=1 and go to DESEL with counter=CS_DESEL-1.
- DESEL: count down to 0, then pulse done and go to IDLE.
- cs_n never rises while spi_req != spi_ack.
- Length arithmetic: LEN_W unsigned; the maximum is 2^LEN_W-1 bytes. No address wrap handling; the flash wraps internally.
- cmd_valid while busy: ignored, since cmd_ready=0.
- Async reset mid-transaction: cs_n goes to 1 immediately, all state clears, no done pulse, any pending rd byte is lost.

Optional Feature:
- Macro SPI_FLASH_FAST_READ_EN.
- Defined:
  - Opcode is 8'h0B.
  - DUMMY state issues exactly one 8'h00 byte (discarded) between ADDR and DATA.
  - spi_fast=1 from CMD through DRAIN, 0 otherwise.
- Undefined:
  - Opcode is READ_CMD.
  - DUMMY is unreachable.
  - spi_fast is tied 0.

Test Plan:
- Read addr 24'h012345, len 3, stub returns AA,BB,CC with rd_ready=1 → MOSI bytes 03,01,23,45,00,00,00; rd_data AA,BB,CC; one done pulse; cs_n low ≥CS_SETUP cycles before first req.
- len=0 → done one cycle after accept; cs_n stays 1; spi_req unchanged.
- len=4, rd_ready held 0 after first byte for 20 cycles → spi_req does not toggle; rd_data stays the first byte; resumes on rd_ready and all 4 bytes arrive in order.
- Two back-to-back requests → cs_n high ≥CS_DESEL cycles between them; cmd_ready=0 throughout the first.
- reset_n pulsed low during ADDR → cs_n=1 asynchronously; after release busy=0, cmd_ready=1, spi_req=0, no done.
- With SPI_FLASH_FAST_READ_EN, addr 0, len 1 → bytes 0B,00,00,00,00,00; spi_fast=1 during transfer; only the final byte is delivered.
